bias_ctrl: RTL and testbench
============================

# bias_ctrl

Sequencing controller for `bias_store`. Per layer it streams bias words from the weight/param loader into `bias_store`, then serves output-group bias requests from the conv/post-processing engine. It issues BRAM reads, holds the 8 returned biases in a register bank and short-circuits repeat requests for the held group. It sits between the param DMA stream, `bias_store` and the requantize stage.

## Interface
Parameters:
- MAX_DEPTH, 256, `bias_store` depth in 128-bit words; must match the instance.
- GRP_W, $clog2(MAX_DEPTH)-1, width of the group index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse; latches cfg_num_groups and begins a layer load.
- cfg_num_groups  in  GRP_W+1  output groups this layer (1..MAX_DEPTH/2).
- s_valid / s_ready  in / out  1  param stream handshake.
- s_data  in  128  4 biases, lane i = bits [i*32 +: 32].
- load_done  out  1  level; high once all 2*cfg_num_groups words are written.
- bs_wr_en  out  1  to `bias_store` wr_en.
- bs_wr_data  out  128  to `bias_store` wr_data.
- bs_rd_en  out  1  to `bias_store` rd_en.
- bs_rd_group  out  GRP_W  to `bias_store` rd_group.
- bs_rd_valid  in  1  from `bias_store`.
- bs_bias  in  32 x 8  from `bias_store` bias_out.
- req_valid / req_ready  in / out  1  group request handshake.
- req_group  in  GRP_W  requested output group.
- bias_valid  out  1  bias_out holds the biases for bias_group.
- bias_group  out  GRP_W  group currently held.
- bias_out  out  32 x 8  held biases.
- err_range  out  1  sticky; a request had req_group >= num_groups, or a request arrived before load_done.

## Operation
- States: IDLE, LOAD, READY, FETCH.
- IDLE: s_ready=0, req_ready=0. cfg_start moves to LOAD, clears wr_cnt, load_done, bias_valid and err_range.
- LOAD: s_ready=1. Each s_valid&&s_ready beat drives bs_wr_en=1 and bs_wr_data=s_data on the same cycle (combinational pass-through), and increments wr_cnt.
  - On the beat where wr_cnt reaches 2*num_groups-1: go to READY and set load_done next cycle.
  - Beats beyond the count are not accepted (s_ready=0 outside LOAD).
- READY: req_ready=1. On handshake:
  - req_group >= num_groups: set err_range, no read, stay in READY.
  - Hit (bias_valid && req_group==bias_group): no BRAM read, stay in READY; bias_valid stays high.
  - Miss: bs_rd_en=1 and bs_rd_group=req_group on that same cycle; bias_valid drops next cycle; go to FETCH.
- FETCH: req_ready=0. On bs_rd_valid, register bs_bias into bias_out, bias_group=requested group, bias_valid=1, return to READY.
- cfg_start in any state aborts and restarts the load. An outstanding read's bs_rd_valid is ignored after a restart.
- A request while in IDLE or LOAD is not accepted (req_ready=0). If req_valid is high while load_done=0 in LOAD, err_range sets.

## Timing
- Reset values: all outputs 0, state IDLE, bias_out all zero.
- Write: zero latency from the accepted beat to bs_wr_en.
- Miss: handshake at cycle T, bs_rd_en at T, bs_rd_valid at T+2 (`bias_store` latency), bias_valid at T+3. Next req_ready at T+3.
- Hit: bias_valid unchanged and req_ready stays high, giving 1 request/cycle throughput.
- bias_out is stable whenever bias_valid=1. It changes only on the FETCH capture edge.
- load_done is cleared in the cycle after cfg_start.
- cfg_num_groups=MAX_DEPTH/2 writes all MAX_DEPTH words. wr_cnt is GRP_W+2 bits, so it does not wrap.

## Structure
- Package `bias_pkg`: the state enum (IDLE, LOAD, READY, FETCH), a `bias_vec_t` typedef (32-bit x 8), BIASES_PER_WORD=4 and WORDS_PER_GROUP=2.
- No sub-module inside the block. The testbench instantiates `bias_ctrl` plus a real `bias_store` with MAX_DEPTH=256.

## Test plan
- Load: cfg_num_groups=4, stream 8 words with bias[n]=n+1 -> exactly 8 bs_wr_en pulses, load_done=1, extra s_valid not accepted.
- Miss sequence: request groups 0,1,2,3 -> bias_out group 2 = [17..24]; each result arrives 3 cycles after its handshake.
- Hit: request group 3 twice back-to-back -> second request accepted the next cycle, no bs_rd_en pulse, bias_valid never drops.
- Range: request group 4 with num_groups=4 -> err_range=1, no bs_rd_en, state stays READY, bias_out unchanged.
- Stream backpressure: s_valid toggling 1,0,1 during LOAD -> wr_cnt counts only accepted beats; readback matches expected.
- Restart: cfg_start in FETCH, then reload with bias[n]=100+n -> the stale rd_valid is ignored, bias_valid=0 until a new miss, and group 0 reads [100..107].

Source files
------------

// File: rtl/bias_pkg.sv
// Shared types and constants for the bias sequencing controller and its bias_store.
package bias_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        FETCH = 2'd3
    } bias_state_t;

    localparam int BIAS_W          = 32;
    localparam int BIASES_PER_WORD = 4;
    localparam int WORDS_PER_GROUP = 2;
    localparam int BIASES_PER_GRP  = BIASES_PER_WORD * WORDS_PER_GROUP;

    typedef logic [BIASES_PER_GRP-1:0][BIAS_W-1:0] bias_vec_t;

endpackage

// File: rtl/bias_store.sv
// Two-bank bias RAM: sequential 128-bit writes, one 8-bias group read per request.
// Read latency is two cycles (registered array read, then an output register).
module bias_store
    import bias_pkg::*;
#(
    parameter int MAX_DEPTH = 256,
    parameter int GRP_W     = $clog2(MAX_DEPTH) - 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_restart,
    input  logic                                 wr_en,
    input  logic [BIAS_W*BIASES_PER_WORD-1:0]    wr_data,
    input  logic                                 rd_en,
    input  logic [GRP_W-1:0]                     rd_group,
    output logic                                 rd_valid,
    output logic [BIAS_W*BIASES_PER_GRP-1:0]     bias_out
);

    localparam int PTR_W  = $clog2(MAX_DEPTH);
    localparam int WORD_W = BIAS_W * BIASES_PER_WORD;

    logic [PTR_W-1:0]                          wr_ptr_q, wr_ptr_d;
    logic                                      rd_pend_q, rd_valid_q;
    logic [BIAS_W*BIASES_PER_GRP-1:0]          bias_out_q;
    logic [WORDS_PER_GROUP-1:0][WORD_W-1:0]    rd_word;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_restart) begin
            wr_ptr_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    // Even words of a group live in bank 0, odd words in bank 1, so one
    // address (the group index) reads a whole group in a single access.
    for (genvar gi = 0; gi < WORDS_PER_GROUP; gi++) begin : g_bank
        logic [WORD_W-1:0] mem [MAX_DEPTH/WORDS_PER_GROUP];
        logic [WORD_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && !wr_restart && (wr_ptr_q[0] == 1'(gi))) begin
                mem[wr_ptr_q[PTR_W-1:1]] <= wr_data;
            end
            if (rd_en) begin
                rd_q <= mem[rd_group];
            end
        end

        assign rd_word[gi] = rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            bias_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_pend_q  <= rd_en;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                bias_out_q <= rd_word;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign bias_out = bias_out_q;

endmodule

// File: rtl/bias_ctrl.sv
// Per-layer bias sequencer: streams param words into bias_store, then serves
// output-group bias requests, holding the last fetched group for repeat hits.
module bias_ctrl
    import bias_pkg::*;
#(
    parameter int MAX_DEPTH = 256,
    parameter int GRP_W     = $clog2(MAX_DEPTH) - 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_start,
    input  logic [GRP_W:0]                       cfg_num_groups,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [BIAS_W*BIASES_PER_WORD-1:0]    s_data,
    output logic                                 load_done,
    output logic                                 bs_wr_en,
    output logic [BIAS_W*BIASES_PER_WORD-1:0]    bs_wr_data,
    output logic                                 bs_rd_en,
    output logic [GRP_W-1:0]                     bs_rd_group,
    input  logic                                 bs_rd_valid,
    input  logic [BIAS_W*BIASES_PER_GRP-1:0]     bs_bias,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [GRP_W-1:0]                     req_group,
    output logic                                 bias_valid,
    output logic [GRP_W-1:0]                     bias_group,
    output logic [BIAS_W*BIASES_PER_GRP-1:0]     bias_out,
    output logic                                 err_range
);

    localparam int CNT_W = GRP_W + 2;

    bias_state_t        state_q, state_d;
    logic [GRP_W:0]     num_groups_q, num_groups_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   wr_last;
    logic               load_done_q, load_done_d;
    logic               bias_valid_q, bias_valid_d;
    logic [GRP_W-1:0]   bias_group_q, bias_group_d;
    logic [GRP_W-1:0]   fetch_group_q, fetch_group_d;
    bias_vec_t          bias_out_q, bias_out_d;
    logic               err_range_q, err_range_d;
    logic               req_in_range;
    logic               req_hit;

    always_comb begin
        state_d       = state_q;
        num_groups_d  = num_groups_q;
        wr_cnt_d      = wr_cnt_q;
        load_done_d   = load_done_q;
        bias_valid_d  = bias_valid_q;
        bias_group_d  = bias_group_q;
        fetch_group_d = fetch_group_q;
        bias_out_d    = bias_out_q;
        err_range_d   = err_range_q;

        s_ready     = 1'b0;
        req_ready   = 1'b0;
        bs_wr_en    = 1'b0;
        bs_wr_data  = '0;
        bs_rd_en    = 1'b0;
        bs_rd_group = '0;

        wr_last      = CNT_W'(num_groups_q) * CNT_W'(WORDS_PER_GROUP) - CNT_W'(1);
        req_in_range = {1'b0, req_group} < num_groups_q;
        req_hit      = bias_valid_q && (req_group == bias_group_q);

        // A restart wins over everything, including a read still in flight:
        // leaving FETCH here is what makes its late rd_valid harmless.
        if (cfg_start) begin
            state_d      = LOAD;
            num_groups_d = cfg_num_groups;
            wr_cnt_d     = '0;
            load_done_d  = 1'b0;
            bias_valid_d = 1'b0;
            err_range_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        bs_wr_en   = 1'b1;
                        bs_wr_data = s_data;
                        wr_cnt_d   = wr_cnt_q + CNT_W'(1);
                        if (wr_cnt_q == wr_last) begin
                            state_d     = READY;
                            load_done_d = 1'b1;
                        end
                    end
                    if (req_valid && !load_done_q) begin
                        err_range_d = 1'b1;
                    end
                end
                READY: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (!req_in_range) begin
                            err_range_d = 1'b1;
                        end else if (!req_hit) begin
                            bs_rd_en      = 1'b1;
                            bs_rd_group   = req_group;
                            fetch_group_d = req_group;
                            bias_valid_d  = 1'b0;
                            state_d       = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (bs_rd_valid) begin
                        bias_out_d   = bs_bias;
                        bias_group_d = fetch_group_q;
                        bias_valid_d = 1'b1;
                        state_d      = READY;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            num_groups_q  <= '0;
            wr_cnt_q      <= '0;
            load_done_q   <= 1'b0;
            bias_valid_q  <= 1'b0;
            bias_group_q  <= '0;
            fetch_group_q <= '0;
            bias_out_q    <= '0;
            err_range_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_groups_q  <= num_groups_d;
            wr_cnt_q      <= wr_cnt_d;
            load_done_q   <= load_done_d;
            bias_valid_q  <= bias_valid_d;
            bias_group_q  <= bias_group_d;
            fetch_group_q <= fetch_group_d;
            bias_out_q    <= bias_out_d;
            err_range_q   <= err_range_d;
        end
    end

    assign load_done  = load_done_q;
    assign bias_valid = bias_valid_q;
    assign bias_group = bias_group_q;
    assign bias_out   = bias_out_q;
    assign err_range  = err_range_q;

endmodule

// File: tb/tb_bias_ctrl.sv
// Self-checking bench for bias_ctrl driving a real bias_store (MAX_DEPTH=256).
module tb_bias_ctrl;

    localparam int MAX_DEPTH = 256;
    localparam int GRP_W     = 7;
    localparam int K_MISS = 0;
    localparam int K_HIT  = 1;
    localparam int K_ERR  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_start;
    logic [GRP_W:0] cfg_num_groups;
    logic         s_valid, s_ready;
    logic [127:0] s_data;
    logic         load_done;
    logic         bs_wr_en;
    logic [127:0] bs_wr_data;
    logic         bs_rd_en;
    logic [GRP_W-1:0] bs_rd_group;
    logic         bs_rd_valid;
    logic [255:0] bs_bias;
    logic         req_valid, req_ready;
    logic [GRP_W-1:0] req_group;
    logic         bias_valid;
    logic [GRP_W-1:0] bias_group;
    logic [255:0] bias_out;
    logic         err_range;

    bias_ctrl #(.MAX_DEPTH(MAX_DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_groups(cfg_num_groups),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .load_done(load_done),
        .bs_wr_en(bs_wr_en), .bs_wr_data(bs_wr_data), .bs_rd_en(bs_rd_en),
        .bs_rd_group(bs_rd_group), .bs_rd_valid(bs_rd_valid), .bs_bias(bs_bias),
        .req_valid(req_valid), .req_ready(req_ready), .req_group(req_group),
        .bias_valid(bias_valid), .bias_group(bias_group), .bias_out(bias_out),
        .err_range(err_range)
    );

    bias_store #(.MAX_DEPTH(MAX_DEPTH)) store (
        .clk(clk), .rst(rst), .wr_restart(cfg_start), .wr_en(bs_wr_en),
        .wr_data(bs_wr_data), .rd_en(bs_rd_en), .rd_group(bs_rd_group),
        .rd_valid(bs_rd_valid), .bias_out(bs_bias)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    always @(posedge clk) begin
        if (bs_wr_en) wr_pulses <= wr_pulses + 1;
        if (bs_rd_en) rd_pulses <= rd_pulses + 1;
    end

    // Reference model: bias contents by flat index, plus what the held register should show.
    logic [31:0]  model_bias [0:1023];
    logic         m_valid;
    int           m_group;
    logic [255:0] m_out;
    logic         m_err;

    typedef struct {
        int grp;
        int kind;
        int first;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkv(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] word_of(input int w);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = model_bias[4*w + i];
        return r;
    endfunction

    function automatic logic [255:0] group_vec(input int g);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = model_bias[8*g + j];
        return r;
    endfunction

    // vmode: 0 = always valid, 1 = alternate 1,0,1..., 2 = random; rnd selects random data.
    task automatic load(input int ng, input bit rnd, input int base, input int vmode, input bit poke);
        int w, tries, wbase;
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_num_groups = (GRP_W+1)'(ng);
        for (int k = 0; k < 8*ng; k++) model_bias[k] = rnd ? 32'($urandom) : 32'(base + k);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        m_valid = 1'b0;
        m_err = poke;
        @(negedge clk);
        check("load_done_clear", int'(load_done), 0);
        @(posedge clk); #1;
        wbase = wr_pulses;
        w = 0;
        tries = 0;
        while (w < 2*ng && tries < 8*ng + 100) begin
            case (vmode)
                0: s_valid = 1'b1;
                1: s_valid = (tries % 2) == 0;
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = word_of(w);
            if (poke && tries == 1) begin
                req_valid = 1'b1;
                req_group = '0;
            end
            @(negedge clk);
            if (poke && tries == 1) check("req_ready_in_load", int'(req_ready), 0);
            if (s_valid && s_ready) begin
                checkv("wr_passthru", {128'd0, bs_wr_data}, {128'd0, s_data});
                w++;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            tries++;
        end
        s_valid = 1'b0;
        check("load_beats", w, 2*ng);
        @(negedge clk);
        check("load_done", int'(load_done), 1);
        check("wr_pulses", wr_pulses - wbase, 2*ng);
        check("err_after_load", int'(err_range), int'(m_err));
        @(posedge clk); #1;
        s_valid = 1'b1;
        @(negedge clk);
        check("extra_s_ready", int'(s_ready), 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("extra_no_write", wr_pulses - wbase, 2*ng);
    endtask

    task automatic apply_req(input int g, input int kind);
        int lat;
        logic rd_seen;
        logic [GRP_W-1:0] rd_grp;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_group = GRP_W'(g);
        lat = 0;
        @(negedge clk);
        while (!req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("req_ready", int'(req_ready), 1);
        rd_seen = bs_rd_en;
        rd_grp = bs_rd_group;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rd_en", int'(rd_seen), int'(kind == K_MISS));
        if (kind == K_MISS) begin
            check("rd_group", int'(rd_grp), g);
            @(negedge clk);
            check("valid_drop", int'(bias_valid), 0);
            lat = 1;
            while (!bias_valid && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            check("miss_latency", lat, 3);
            m_valid = 1'b1;
            m_group = g;
            m_out = group_vec(g);
        end else begin
            if (kind == K_ERR) m_err = 1'b1;
            @(negedge clk);
        end
        $display("req group=%0d kind=%0d valid=%0b bias_group=%0d lane0=%0d err=%0b",
                 g, kind, bias_valid, bias_group, bias_out[31:0], err_range);
        check("bias_valid", int'(bias_valid), int'(m_valid));
        check("bias_group", int'(bias_group), m_group);
        checkv("bias_out", bias_out, m_out);
        check("err_range", int'(err_range), int'(m_err));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, ng, g, kind;

        tbl[0] = '{0, K_MISS, 1};
        tbl[1] = '{1, K_MISS, 9};
        tbl[2] = '{2, K_MISS, 17};
        tbl[3] = '{3, K_MISS, 25};
        tbl[4] = '{3, K_HIT,  25};
        tbl[5] = '{4, K_ERR,  25};
        tbl[6] = '{3, K_HIT,  25};
        tbl[7] = '{1, K_MISS, 9};
        tbl[8] = '{2, K_MISS, 17};

        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_num_groups = '0;
        s_valid = 1'b0;
        s_data = '0;
        req_valid = 1'b0;
        req_group = '0;
        m_valid = 1'b0;
        m_group = 0;
        m_out = '0;
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_load_done", int'(load_done), 0);
        check("rst_bias_valid", int'(bias_valid), 0);
        check("rst_err", int'(err_range), 0);
        check("rst_rd_en", int'(bs_rd_en), 0);
        checkv("rst_bias_out", bias_out, '0);

        // Basic load: 4 groups, bias[n] = n+1.
        load(4, 1'b0, 1, 0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            apply_req(tbl[i].grp, tbl[i].kind);
            check("tbl_lane0", int'(bias_out[31:0]), tbl[i].first);
        end
        checkv("group2_contents", bias_out,
               {32'd24, 32'd23, 32'd22, 32'd21, 32'd20, 32'd19, 32'd18, 32'd17});

        // Back-to-back hits on group 3.
        apply_req(3, K_MISS);
        rd0 = rd_pulses;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_group = 3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hit_req_ready", int'(req_ready), 1);
            check("hit_bias_valid", int'(bias_valid), 1);
            check("hit_no_rd", int'(bs_rd_en), 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("hit_rd_pulses", rd_pulses - rd0, 0);
        checkv("hit_bias_out", bias_out, m_out);

        // Restart while a fetch is in flight; its late rd_valid must be dropped.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_group = 0;
        @(negedge clk);
        check("rs_req_ready", int'(req_ready), 1);
        check("rs_rd_en", int'(bs_rd_en), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cfg_start = 1'b1;
        cfg_num_groups = 4;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        m_valid = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        check("rs_load_done", int'(load_done), 0);
        check("rs_bias_valid", int'(bias_valid), 0);
        check("rs_err", int'(err_range), 0);
        repeat (3) @(negedge clk);
        check("rs_stale_valid", int'(bias_valid), 0);
        checkv("rs_stale_out", bias_out, m_out);

        // Reload with bias[n] = 100+n, alternating s_valid and a premature request.
        load(4, 1'b0, 100, 1, 1'b1);
        check("reload_valid_low", int'(bias_valid), 0);
        apply_req(0, K_MISS);
        checkv("reload_group0", bias_out,
               {32'd107, 32'd106, 32'd105, 32'd104, 32'd103, 32'd102, 32'd101, 32'd100});

        // Randomized: full-depth load, then a small random layer.
        for (int cfg = 0; cfg < 2; cfg++) begin
            ng = (cfg == 0) ? MAX_DEPTH/2 : int'($urandom_range(1, 20));
            load(ng, 1'b1, 0, 2, 1'b0);
            for (int r = 0; r < 40; r++) begin
                if (m_valid && $urandom_range(0, 3) == 0) g = m_group;
                else g = int'($urandom_range(0, ng + 2));
                if (g > 127) g = 127;
                if (g >= ng) kind = K_ERR;
                else if (m_valid && g == m_group) kind = K_HIT;
                else kind = K_MISS;
                apply_req(g, kind);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
